// File: rtl/argmax_sel_pkg.sv
// Shared types and helpers for argmax_sel: FSM state encoding, class-index
// width derivation and the bit position of class j inside the packed score vector.
package argmax_sel_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   function automatic int cid_width(input int class_num);
      return (class_num > 1) ? $clog2(class_num) : 1;
   endfunction

   // Class 0 occupies the most significant slice of the packed vector.
   function automatic int slice_lsb(input int j, input int class_num, input int d_wl);
      return (class_num - j - 1) * d_wl;
   endfunction

endpackage

// File: rtl/argmax_sel.sv
// Sequential argmax over CLASS_NUM signed scores, one compare per clock.
// Optional build macro ARGMAX_SEL_MARGIN_EN adds a top-1 minus runner-up margin output.
module argmax_sel
   import argmax_sel_pkg::*;
#(
   parameter int  CLASS_NUM = 30,
   parameter int  D_WL      = 16,
   localparam int CID_W     = cid_width(CLASS_NUM)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [CLASS_NUM*D_WL-1:0] d_in,
   output logic                      busy,
   output logic                      o_valid,
   output logic [CID_W-1:0]          class_id,
`ifdef ARGMAX_SEL_MARGIN_EN
   output logic [D_WL:0]             margin,
`endif
   output logic [D_WL-1:0]           max_val
);

   state_e                    state_q;
   logic [CLASS_NUM*D_WL-1:0] buf_q;
   logic signed [D_WL-1:0]    best_val_q;
   logic [CID_W-1:0]          best_idx_q;
   logic [CID_W-1:0]          scan_idx_q;
   logic                      busy_q;
   logic                      o_valid_q;
   logic [CID_W-1:0]          class_id_q;
   logic [D_WL-1:0]           max_val_q;

   logic signed [D_WL-1:0]    first_val;
   logic signed [D_WL-1:0]    cand;
   logic signed [D_WL-1:0]    best_val_d;
   logic [CID_W-1:0]          best_idx_d;
   logic                      gt;
   logic                      last;

`ifdef ARGMAX_SEL_MARGIN_EN
   logic signed [D_WL-1:0]    sec_val_q;
   logic signed [D_WL-1:0]    sec_val_d;
   logic [D_WL:0]             margin_q;
   logic [D_WL:0]             margin_d;
`endif

   assign first_val = $signed(d_in[slice_lsb(0, CLASS_NUM, D_WL) +: D_WL]);

   always_comb begin
      cand       = $signed(buf_q[slice_lsb(int'(scan_idx_q), CLASS_NUM, D_WL) +: D_WL]);
      gt         = (cand > best_val_q);
      best_val_d = gt ? cand : best_val_q;
      best_idx_d = gt ? scan_idx_q : best_idx_q;
      last       = (scan_idx_q == CID_W'(CLASS_NUM - 1));
`ifdef ARGMAX_SEL_MARGIN_EN
      // An equal score lands in the runner-up slot, so ties yield a zero margin.
      if (gt)
         sec_val_d = best_val_q;
      else if (cand >= sec_val_q)
         sec_val_d = cand;
      else
         sec_val_d = sec_val_q;
      margin_d = {best_val_d[D_WL-1], best_val_d} - {sec_val_d[D_WL-1], sec_val_d};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         best_val_q <= '0;
         best_idx_q <= '0;
         scan_idx_q <= '0;
         busy_q     <= 1'b0;
         o_valid_q  <= 1'b0;
         class_id_q <= '0;
         max_val_q  <= '0;
`ifdef ARGMAX_SEL_MARGIN_EN
         sec_val_q  <= '0;
         margin_q   <= '0;
`endif
      end else begin
         o_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  buf_q      <= d_in;
                  best_val_q <= first_val;
                  best_idx_q <= '0;
                  scan_idx_q <= CID_W'(1);
                  busy_q     <= 1'b1;
                  state_q    <= SCAN;
`ifdef ARGMAX_SEL_MARGIN_EN
                  // Most negative value: the first non-winning compare always claims the slot.
                  sec_val_q  <= {1'b1, {(D_WL-1){1'b0}}};
`endif
               end
            end
            SCAN: begin
               best_val_q <= best_val_d;
               best_idx_q <= best_idx_d;
               scan_idx_q <= scan_idx_q + CID_W'(1);
`ifdef ARGMAX_SEL_MARGIN_EN
               sec_val_q  <= sec_val_d;
`endif
               if (last) begin
                  class_id_q <= best_idx_d;
                  max_val_q  <= best_val_d;
                  o_valid_q  <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
`ifdef ARGMAX_SEL_MARGIN_EN
                  margin_q   <= margin_d;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign o_valid  = o_valid_q;
   assign class_id = class_id_q;
   assign max_val  = max_val_q;
`ifdef ARGMAX_SEL_MARGIN_EN
   assign margin   = margin_q;
`endif

endmodule
